// File: rtl/cache_set_if.sv
// rtl/cache_set_if.sv - request/response bundle between a cache-set initiator and responder
interface cache_set_if #(
    parameter int TAG_W = 24,
    parameter int OFF_W = 6
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       write_en;
    logic [OFF_W-1:0] block_offset;
    logic [63:0]      write_data;
    logic [1:0]       data_size;
    logic [TAG_W-1:0] tag;
    logic [63:0]      out_data;
    logic             miss;
    logic             data_ready;

    modport master (
        output req_valid, write_en, block_offset, write_data, data_size, tag,
        input  req_ready, out_data, miss, data_ready
    );

    modport slave (
        input  req_valid, write_en, block_offset, write_data, data_size, tag,
        output req_ready, out_data, miss, data_ready
    );
endinterface

// File: rtl/cache_set_responder.sv
// rtl/cache_set_responder.sv - single-set N-way cache responder, true-LRU, write-allocate, write-back
module cache_set_responder #(
    parameter int WAYS       = 8,
    parameter int TAG_W      = 24,
    parameter int LINE_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cache_set_if.slave              bus,
    output logic                    fill_req,
    output logic [TAG_W-1:0]        fill_tag,
    input  logic                    fill_valid,
    input  logic [LINE_BYTES*8-1:0] fill_data,
    output logic                    evict_valid,
    output logic [TAG_W-1:0]        evict_tag,
    output logic [LINE_BYTES*8-1:0] evict_data,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int AW     = $clog2(WAYS);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL_WAIT, S_RESPOND} state_t;

    state_t                      state_q, state_d;
    logic                        req_ready_q, req_ready_d;
    logic                        data_ready_q, data_ready_d;
    logic                        miss_q, miss_d;
    logic [63:0]                 out_data_q, out_data_d;
    logic                        fill_req_q, fill_req_d;
    logic [TAG_W-1:0]            fill_tag_q, fill_tag_d;
    logic                        evict_valid_q, evict_valid_d;
    logic [TAG_W-1:0]            evict_tag_q, evict_tag_d;
    logic [LINE_W-1:0]           evict_data_q, evict_data_d;
    logic [31:0]                 hit_count_q, hit_count_d;
    logic [31:0]                 miss_count_q, miss_count_d;

    logic                        op_write_q, op_write_d;
    logic [OFF_W-1:0]            req_off_q, req_off_d;
    logic [1:0]                  req_size_q, req_size_d;
    logic [63:0]                 req_wdata_q, req_wdata_d;
    logic [TAG_W-1:0]            req_tag_q, req_tag_d;
    logic [AW-1:0]               victim_q, victim_d;

    logic [WAYS-1:0][TAG_W-1:0]  way_tag_q, way_tag_d;
    logic [WAYS-1:0]             way_valid_q, way_valid_d;
    logic [WAYS-1:0]             way_dirty_q, way_dirty_d;
    logic [WAYS-1:0][AW-1:0]     way_age_q, way_age_d;

    // Line contents carry no reset; valid bits gate every use.
    logic [LINE_W-1:0]           line_mem [WAYS];
    logic                        line_we;
    logic [AW-1:0]               line_waddr;
    logic [LINE_W-1:0]           line_wdata;

    logic                        hit;
    logic [AW-1:0]               hit_way;
    logic                        has_free;
    logic [AW-1:0]               victim_sel;
    logic [AW-1:0]               max_age;
    logic                        touch_en;
    logic [AW-1:0]               touch_way;
    logic [AW-1:0]               touch_prev;

    function automatic logic [OFF_W-1:0] align_off(input logic [OFF_W-1:0] off,
                                                   input logic [1:0] size);
        return off & ~((OFF_W'(1) << size) - OFF_W'(1));
    endfunction

    function automatic logic [63:0] read_bytes(input logic [LINE_W-1:0] line,
                                               input logic [OFF_W-1:0] off,
                                               input logic [1:0] size);
        logic [LINE_W-1:0] sh;
        logic [63:0]       v;
        sh = line >> {align_off(off, size), 3'b000};
        v  = sh[63:0];
        case (size)
            2'd0:    v = {56'd0, v[7:0]};
            2'd1:    v = {48'd0, v[15:0]};
            2'd2:    v = {32'd0, v[31:0]};
            default: v = v;
        endcase
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] merge_bytes(input logic [LINE_W-1:0] line,
                                                      input logic [OFF_W-1:0] off,
                                                      input logic [1:0] size,
                                                      input logic [63:0] wdata);
        logic [LINE_W-1:0] r;
        int                base;
        r    = line;
        base = int'(align_off(off, size));
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << size)) r[(base + i) * 8 +: 8] = wdata[i * 8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && way_valid_q[w] && way_tag_q[w] == req_tag_q) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
    end

    // Prefer the lowest free way; otherwise the oldest (ages are a permutation).
    always_comb begin
        has_free   = 1'b0;
        victim_sel = '0;
        max_age    = way_age_q[0];
        for (int w = 0; w < WAYS; w++) begin
            if (!has_free && !way_valid_q[w]) begin
                has_free   = 1'b1;
                victim_sel = AW'(w);
            end
        end
        if (!has_free) begin
            for (int w = 1; w < WAYS; w++) begin
                if (way_age_q[w] > max_age) begin
                    max_age    = way_age_q[w];
                    victim_sel = AW'(w);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        data_ready_d  = 1'b0;
        miss_d        = 1'b0;
        out_data_d    = out_data_q;
        fill_req_d    = fill_req_q;
        fill_tag_d    = fill_tag_q;
        evict_valid_d = 1'b0;
        evict_tag_d   = evict_tag_q;
        evict_data_d  = evict_data_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        op_write_d    = op_write_q;
        req_off_d     = req_off_q;
        req_size_d    = req_size_q;
        req_wdata_d   = req_wdata_q;
        req_tag_d     = req_tag_q;
        victim_d      = victim_q;
        way_tag_d     = way_tag_q;
        way_valid_d   = way_valid_q;
        way_dirty_d   = way_dirty_q;
        way_age_d     = way_age_q;
        line_we       = 1'b0;
        line_waddr    = '0;
        line_wdata    = '0;
        touch_en      = 1'b0;
        touch_way     = '0;
        touch_prev    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_write_d  = (bus.write_en == 2'd1);
                    req_off_d   = bus.block_offset;
                    req_size_d  = bus.data_size;
                    req_wdata_d = bus.write_data;
                    req_tag_d   = bus.tag;
                    if (!bus.write_en[1]) begin
                        state_d     = S_LOOKUP;
                        req_ready_d = 1'b0;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    if (op_write_q) begin
                        line_we              = 1'b1;
                        line_waddr           = hit_way;
                        line_wdata           = merge_bytes(line_mem[hit_way], req_off_q,
                                                           req_size_q, req_wdata_q);
                        way_dirty_d[hit_way] = 1'b1;
                        out_data_d           = '0;
                    end else begin
                        out_data_d = read_bytes(line_mem[hit_way], req_off_q, req_size_q);
                    end
                    touch_en     = 1'b1;
                    touch_way    = hit_way;
                    touch_prev   = way_age_q[hit_way];
                    hit_count_d  = hit_count_q + 32'd1;
                    data_ready_d = 1'b1;
                    state_d      = S_RESPOND;
                end else begin
                    victim_d = victim_sel;
                    if (way_valid_q[victim_sel] && way_dirty_q[victim_sel]) begin
                        evict_valid_d = 1'b1;
                        evict_tag_d   = way_tag_q[victim_sel];
                        evict_data_d  = line_mem[victim_sel];
                    end
                    fill_req_d = 1'b1;
                    fill_tag_d = req_tag_q;
                    state_d    = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                if (fill_valid) begin
                    line_we    = 1'b1;
                    line_waddr = victim_q;
                    if (op_write_q) begin
                        line_wdata = merge_bytes(fill_data, req_off_q, req_size_q, req_wdata_q);
                        out_data_d = '0;
                    end else begin
                        line_wdata = fill_data;
                        out_data_d = read_bytes(fill_data, req_off_q, req_size_q);
                    end
                    way_tag_d[victim_q]   = req_tag_q;
                    way_valid_d[victim_q] = 1'b1;
                    way_dirty_d[victim_q] = op_write_q;
                    // A fill ages every other valid way, as if it came from the back.
                    touch_en     = 1'b1;
                    touch_way    = victim_q;
                    touch_prev   = AW'(WAYS - 1);
                    miss_count_d = miss_count_q + 32'd1;
                    fill_req_d   = 1'b0;
                    data_ready_d = 1'b1;
                    miss_d       = 1'b1;
                    state_d      = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AW'(w) == touch_way) begin
                    way_age_d[w] = '0;
                end else if (way_valid_q[w] && way_age_q[w] < touch_prev) begin
                    way_age_d[w] = way_age_q[w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            data_ready_q  <= 1'b0;
            miss_q        <= 1'b0;
            out_data_q    <= '0;
            fill_req_q    <= 1'b0;
            fill_tag_q    <= '0;
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            op_write_q    <= 1'b0;
            req_off_q     <= '0;
            req_size_q    <= '0;
            req_wdata_q   <= '0;
            req_tag_q     <= '0;
            victim_q      <= '0;
            way_tag_q     <= '0;
            way_valid_q   <= '0;
            way_dirty_q   <= '0;
            way_age_q     <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            data_ready_q  <= data_ready_d;
            miss_q        <= miss_d;
            out_data_q    <= out_data_d;
            fill_req_q    <= fill_req_d;
            fill_tag_q    <= fill_tag_d;
            evict_valid_q <= evict_valid_d;
            evict_tag_q   <= evict_tag_d;
            evict_data_q  <= evict_data_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            op_write_q    <= op_write_d;
            req_off_q     <= req_off_d;
            req_size_q    <= req_size_d;
            req_wdata_q   <= req_wdata_d;
            req_tag_q     <= req_tag_d;
            victim_q      <= victim_d;
            way_tag_q     <= way_tag_d;
            way_valid_q   <= way_valid_d;
            way_dirty_q   <= way_dirty_d;
            way_age_q     <= way_age_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) line_mem[line_waddr] <= line_wdata;
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.data_ready = data_ready_q;
    assign bus.miss       = miss_q;
    assign bus.out_data   = out_data_q;
    assign fill_req       = fill_req_q;
    assign fill_tag       = fill_tag_q;
    assign evict_valid    = evict_valid_q;
    assign evict_tag      = evict_tag_q;
    assign evict_data     = evict_data_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;
endmodule

// File: tb/tb_cache_set_responder.sv
// tb/tb_cache_set_responder.sv - directed plus randomized bench with a recency-list cache model
module tb_cache_set_responder;
    localparam int WAYS = 8;

    logic         clk;
    logic         rst_n = 1'b1;
    logic         fill_req;
    logic [23:0]  fill_tag;
    logic         fill_valid;
    logic [511:0] fill_data;
    logic         evict_valid;
    logic [23:0]  evict_tag;
    logic [511:0] evict_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    cache_set_if #(.TAG_W(24), .OFF_W(6)) bus ();

    cache_set_responder #(.WAYS(WAYS), .TAG_W(24), .LINE_BYTES(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .fill_req    (fill_req),
        .fill_tag    (fill_tag),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .evict_valid (evict_valid),
        .evict_tag   (evict_tag),
        .evict_data  (evict_data),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_data [WAYS][64];
    bit          m_valid [WAYS];
    bit          m_dirty [WAYS];
    logic [23:0] m_tag [WAYS];
    int          lru_q[$];
    int          exp_hits;
    int          exp_misses;

    logic [63:0]  last_out;
    logic         last_miss;
    logic         obs_ev_seen;
    logic [23:0]  obs_ev_tag;
    logic [511:0] obs_ev_data;

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < WAYS; w++) begin
            m_valid[w] = 1'b0;
            m_dirty[w] = 1'b0;
            m_tag[w]   = '0;
        end
        lru_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    function automatic logic [511:0] m_line(input int w);
        logic [511:0] r;
        for (int b = 0; b < 64; b++) r[b * 8 +: 8] = m_data[w][b];
        return r;
    endfunction

    function automatic void touch(input int w);
        for (int i = 0; i < lru_q.size(); i++) begin
            if (lru_q[i] == w) begin
                lru_q.delete(i);
                break;
            end
        end
        lru_q.push_front(w);
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i * 32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [23:0] t, input logic [5:0] off,
                          input logic [1:0] sz, input logic [63:0] wd, input logic [511:0] fd);
        int           w;
        int           n;
        int           eff;
        int           k;
        bit           is_hit;
        bit           ev_exp;
        logic [23:0]  ev_tag;
        logic [511:0] ev_line;
        logic [63:0]  exp_out;

        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid    = 1'b1;
        bus.write_en     = op;
        bus.tag          = t;
        bus.block_offset = off;
        bus.data_size    = sz;
        bus.write_data   = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (op[1]) begin
            chk("noop_no_resp", bus.data_ready, 1'b0);
            chk("noop_ready", bus.req_ready, 1'b1);
            chk("noop_hits", hit_count, 32'(exp_hits));
            chk("noop_misses", miss_count, 32'(exp_misses));
            return;
        end
        chk("lookup_busy", bus.req_ready, 1'b0);
        chk("lookup_no_resp", bus.data_ready, 1'b0);

        n   = 1 << sz;
        eff = int'(off) - (int'(off) % n);
        w   = -1;
        for (int i = 0; i < WAYS; i++) if (m_valid[i] && m_tag[i] == t) w = i;
        is_hit  = (w >= 0);
        ev_exp  = 1'b0;
        ev_tag  = '0;
        ev_line = '0;
        if (!is_hit) begin
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[i]) w = i;
            if (w < 0) w = lru_q[$];
            ev_exp  = m_valid[w] && m_dirty[w];
            ev_tag  = m_tag[w];
            ev_line = m_line(w);
            for (int b = 0; b < 64; b++) m_data[w][b] = fd[b * 8 +: 8];
            m_valid[w] = 1'b1;
            m_dirty[w] = 1'b0;
            m_tag[w]   = t;
            exp_misses++;
        end else begin
            exp_hits++;
        end
        exp_out = '0;
        if (op == 2'd1) begin
            for (int i = 0; i < n; i++) m_data[w][eff + i] = wd[i * 8 +: 8];
            m_dirty[w] = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) exp_out[i * 8 +: 8] = m_data[w][eff + i];
        end
        touch(w);

        if (!is_hit) begin
            @(negedge clk);
            chk("fill_req_up", fill_req, 1'b1);
            chk("fill_tag", fill_tag, t);
            chk("evict_valid", evict_valid, ev_exp);
            obs_ev_seen = evict_valid;
            obs_ev_tag  = evict_tag;
            obs_ev_data = evict_data;
            if (ev_exp) begin
                chk("evict_tag", evict_tag, ev_tag);
                chk("evict_data", evict_data, ev_line);
            end
            k = $urandom_range(0, 3);
            repeat (k) begin
                @(negedge clk);
                chk("evict_one_cycle", evict_valid, 1'b0);
                chk("fill_req_hold", fill_req, 1'b1);
                chk("fill_wait_no_resp", bus.data_ready, 1'b0);
            end
            fill_valid = 1'b1;
            fill_data  = fd;
            @(negedge clk);
            fill_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
        chk("data_ready", bus.data_ready, 1'b1);
        chk("miss_flag", bus.miss, !is_hit);
        chk("out_data", bus.out_data, exp_out);
        chk("fill_req_down", fill_req, 1'b0);
        chk("hit_count", hit_count, 32'(exp_hits));
        chk("miss_count", miss_count, 32'(exp_misses));
        last_out  = bus.out_data;
        last_miss = bus.miss;
    endtask

    initial begin
        logic [1:0] op;
        int         r;

        bus.req_valid    = 1'b0;
        bus.write_en     = '0;
        bus.tag          = '0;
        bus.block_offset = '0;
        bus.data_size    = '0;
        bus.write_data   = '0;
        fill_valid       = 1'b0;
        fill_data        = '0;
        obs_ev_seen      = 1'b0;
        obs_ev_tag       = '0;
        obs_ev_data      = '0;
        last_out         = '0;
        last_miss        = 1'b0;
        model_reset();

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_data_ready", bus.data_ready, 1'b0);
        chk("rst_miss", bus.miss, 1'b0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_fill_req", fill_req, 1'b0);
        chk("rst_fill_tag", fill_tag, 24'd0);
        chk("rst_evict_valid", evict_valid, 1'b0);
        chk("rst_evict_tag", evict_tag, 24'd0);
        chk("rst_evict_data", evict_data, 512'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);

        do_req(2'd1, 24'd16, 6'd0, 2'd0, 64'd3, {64{8'hAA}});
        chk("plan_write_miss", last_miss, 1'b1);
        chk("plan_miss_count", miss_count, 32'd1);

        do_req(2'd0, 24'd16, 6'd0, 2'd3, 64'd0, rand_line());
        chk("plan_read_hit", last_out, 64'hAAAAAAAAAAAAAA03);
        chk("plan_hit_count", hit_count, 32'd1);

        for (int t = 17; t <= 23; t++)
            do_req(2'd0, 24'(t), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 64'd0, rand_line());
        do_req(2'd0, 24'd24, 6'd0, 2'd3, 64'd0, rand_line());
        chk("plan_evict_seen", obs_ev_seen, 1'b1);
        chk("plan_evict_tag", obs_ev_tag, 24'd16);
        chk("plan_evict_byte0", obs_ev_data[7:0], 8'h03);

        do_req(2'd2, 24'd24, 6'd0, 2'd3, 64'd0, '0);
        do_req(2'd3, 24'd99, 6'd0, 2'd3, 64'd0, '0);
        do_req(2'd0, 24'd24, 6'd8, 2'd3, 64'd0, rand_line());

        do_req(2'd1, 24'd24, 6'd3, 2'd1, 64'hBEEF, rand_line());
        do_req(2'd0, 24'd24, 6'd0, 2'd2, 64'd0, rand_line());
        chk("plan_beef_hi", last_out[31:16], 16'hBEEF);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.write_en  = 2'd0;
        bus.tag       = 24'd77;
        bus.data_size = 2'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_fill_req_before", fill_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_fill_req_async", fill_req, 1'b0);
        chk("midrst_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fill_valid = 1'b1;
        fill_data  = rand_line();
        @(negedge clk);
        fill_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_resp", bus.data_ready, 1'b0);
            chk("midrst_miss_count", miss_count, 32'd0);
            chk("midrst_idle", bus.req_ready, 1'b1);
        end
        do_req(2'd0, 24'd16, 6'd0, 2'd3, 64'd0, rand_line());
        chk("midrst_old_tag_misses", last_miss, 1'b1);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       op = 2'd0;
            else if (r < 9)  op = 2'd1;
            else             op = 2'($urandom_range(2, 3));
            do_req(op, 24'($urandom_range(32, 43)), 6'($urandom_range(0, 63)),
                   2'($urandom_range(0, 3)), {$urandom(), $urandom()}, rand_line());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_set_responder.md
Name: cache_set_responder

Overview:
- Responder end of the cache-set request interface: accepts read/write/no-op requests (tag, block offset, size, data) from an initiator and returns data_ready/miss/out_data.
- One 8-way set of 64-byte lines. True-LRU replacement, write-allocate, write-back.
- Misses request a line from the next level over a fill handshake. Dirty victims are pushed out on an evict strobe.
- Sits between the request driver (bench or core model) and the next cache level in the i7 hierarchy model.

Parameters:
- WAYS, 8, number of ways (power of two, 2..16).
- TAG_W, 24, tag width.
- LINE_BYTES, 64, line size. Offset width is log2(LINE_BYTES) = 6.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- write_en  in  2  op code: 0 read, 1 write, 2 no-op, 3 treated as no-op.
- block_offset  in  6  byte offset within the line.
- write_data  in  64  store data, little-endian, low bytes used.
- data_size  in  2  access size: 0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b.
- tag  in  TAG_W  line tag.
- out_data  out  64  read result, zero-extended.
- miss  out  1  qualifies data_ready: response came via fill.
- data_ready  out  1  one-cycle response strobe.
- fill_req  out  1  line request to the next level.
- fill_tag  out  TAG_W  tag being fetched.
- fill_valid  in  1  fill data valid.
- fill_data  in  512  line contents, byte 0 in bits [7:0].
- evict_valid  out  1  one-cycle dirty writeback strobe.
- evict_tag  out  TAG_W  victim tag.
- evict_data  out  512  victim line.
- hit_count  out  32  completed hits, wraps.
- miss_count  out  32  completed misses, wraps.

Behaviour:
- Reset (async assert, sync release):
  - All valid, dirty and LRU ages cleared; state = IDLE.
  - req_ready = 1; data_ready, miss, fill_req and evict_valid = 0.
  - out_data, fill_tag, evict_tag and evict_data = 0; both counters = 0.
  - Line data need not be cleared.
- States: IDLE, LOOKUP, FILL_WAIT, RESPOND. req_ready = 1 only in IDLE.
- IDLE:
  - A handshake occurs when req_valid && req_ready. The request is latched.
  - Ops 0/1 go to LOOKUP. Ops 2/3 are consumed with no response and no state change.
- Alignment: effective offset = block_offset & ~(2^data_size − 1). Accesses never cross a line.
- LOOKUP, hit (tag matches a valid way):
  - Read: selected bytes go to out_data.
  - Write: merges 2^data_size bytes into the line and sets dirty.
  - LRU updated; hit_count increments.
  - Next cycle: data_ready = 1, miss = 0, return to IDLE.
  - Hit latency: data_ready in the 2nd cycle after the handshake edge.
- LOOKUP, miss:
  - Victim is the lowest-index invalid way, else the way with maximum age.
  - If the victim is valid and dirty: evict_valid = 1 for exactly one cycle (the cycle after LOOKUP), with evict_tag/evict_data. There is no back-pressure.
  - Then FILL_WAIT with fill_req = 1 and fill_tag = latched tag.
- FILL_WAIT:
  - fill_req stays high until fill_valid is sampled high. fill_valid outside FILL_WAIT is ignored.
  - On fill_valid: install fill_data in the victim (valid = 1, dirty = 0), then apply the latched op. A write merges and sets dirty.
  - Same cycle: update LRU, increment miss_count, drop fill_req, go to RESPOND.
- RESPOND: data_ready = 1, miss = 1, out_data valid (reads). Next cycle: IDLE.
- out_data holds its value until the next response. For writes, out_data = 0 at response.
- LRU: each way holds a log2(WAYS)-bit age.
  - On any hit or fill, the accessed way's age becomes 0.
  - Valid ways with age below the accessed way's previous age increment.
  - A newly filled way counts as previous age WAYS−1.
  - Ages stay a permutation over valid ways.
- Counters wrap 0xFFFFFFFF → 0.
- Reset mid-operation: the in-flight request is dropped with no response, fill_req falls immediately, and pending evict is cancelled.
- Back-to-back: the next request is accepted in the cycle after data_ready.

Test Plan:
- Reset; write_en=1, tag=16, offset=0, size=0, data=3 → miss path: fill_req=1, fill_tag=16. fill_valid with fill_data all 0xAA → data_ready=1, miss=1; miss_count=1.
- Read tag=16, offset=0, size=3 → hit: data_ready 2 cycles after handshake, miss=0, out_data=0xAAAAAAAAAAAAAA03; hit_count=1.
- Fill tags 17..23 (read misses), then access tag 24 → victim is tag 16 (LRU, dirty): evict_valid one cycle, evict_tag=16, evict_data byte0=0x03.
- write_en=2 handshake → no data_ready, counters unchanged. Next read accepted the following cycle.
- size=1, offset=3, write 0xBEEF on a hit → bytes 2..3 = EF,BE. Read size=2 offset=0 → 0xBEEFxxxx with low bytes unchanged.
- Assert rst_n low during FILL_WAIT → fill_req=0 asynchronously. A later fill_valid is ignored. A read of the old tag misses.
